// File: rtl/hdlc_rx_monitor.sv
// In-line protocol monitor for the HDLC Rx path: checks flag/abort response latency,
// DataOut stability while the line idles, and idle timeout; reports via sticky flags and counters.
module hdlc_rx_monitor #(
    parameter int unsigned FLAG_LAT     = 2,
    parameter int unsigned ABORT_LAT    = 1,
    parameter int unsigned IDLE_LEN     = 8,
    parameter int unsigned IDLE_TIMEOUT = 100,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Rx,
    input  logic             Rx_FlagDetect,
    input  logic             Rx_ValidFrame,
    input  logic             Rx_AbortDetect,
    input  logic             Rx_AbortSignal,
    input  logic [31:0]      DataOut,
    input  logic             ClrErr,
    output logic [3:0]       ErrFlag,
    output logic [CNT_W-1:0] ErrCnt,
    output logic [1:0]       FirstErrCode,
    output logic             FirstErrValid,
    output logic             Idle
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ERR_N    = 4;
    localparam int unsigned OC_W     = $clog2(IDLE_LEN);
    localparam int unsigned TMR_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int unsigned TMR_LAST = (IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1;
    localparam int unsigned SUM_W    = CNT_W + 3;
    localparam logic [7:0]  FLAG_PAT = 8'h7E;

    localparam logic [0:0] S_HUNT = 1'b0;
    localparam logic [0:0] S_IDLE = 1'b1;

    // Flag / abort latency pipes
    logic [7:0]           sreg_q,       sreg_d;
    logic [FLAG_LAT-1:0]  flag_pipe_q,  flag_pipe_d;
    logic [ABORT_LAT-1:0] abort_pipe_q, abort_pipe_d;
    logic                 flag_hit;
    logic                 abort_hit;

    // Idle FSM
    logic [0:0]           state_q, state_d;
    logic [OC_W-1:0]      ones_q,  ones_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0]    cap_q,   cap_d;
    logic                 idle_data_err;
    logic                 idle_to_err;

    // Error bookkeeping
    logic [ERR_N-1:0]     err_new;
    logic [ERR_N-1:0]     err_flag_q,    err_flag_d;
    logic [CNT_W-1:0]     err_cnt_q,     err_cnt_d;
    logic [1:0]           first_code_q,  first_code_d;
    logic                 first_valid_q, first_valid_d;
    logic [ERR_N-1:0]     base_flag;
    logic [CNT_W-1:0]     base_cnt;
    logic                 base_valid;
    logic [1:0]           base_code;
    logic [2:0]           err_pop;
    logic [SUM_W-1:0]     cnt_sum;
    logic [1:0]           err_low;

    // Line history and pending-expectation pipes; a hit enters at bit 0 and is checked at the top bit
    always_comb begin
        sreg_d       = {sreg_q[6:0], Rx};
        flag_hit     = (sreg_d == FLAG_PAT);
        abort_hit    = Rx_AbortDetect && Rx_ValidFrame;
        flag_pipe_d  = FLAG_LAT'({flag_pipe_q, flag_hit});
        abort_pipe_d = ABORT_LAT'({abort_pipe_q, abort_hit});
        if (!En) begin
            sreg_d       = '0;
            flag_pipe_d  = '0;
            abort_pipe_d = '0;
        end
    end

    // Idle-watch next-state and per-cycle idle errors
    always_comb begin
        state_d       = state_q;
        ones_d        = ones_q;
        timer_d       = timer_q;
        cap_d         = cap_q;
        idle_data_err = 1'b0;
        idle_to_err   = 1'b0;
        if (!En) begin
            state_d = S_HUNT;
            ones_d  = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_HUNT: begin
                    if (Rx) begin
                        if (ones_q == OC_W'(IDLE_LEN - 1)) begin
                            state_d = S_IDLE;
                            cap_d   = DataOut;
                            timer_d = '0;
                        end else begin
                            ones_d = ones_q + OC_W'(1);
                        end
                    end else begin
                        ones_d = '0;
                    end
                end
                S_IDLE: begin
                    if (!Rx) begin
                        state_d = S_HUNT;
                        ones_d  = '0;
                    end else begin
                        if (DataOut != cap_q) begin
                            idle_data_err = 1'b1;
                            cap_d         = DataOut;
                        end
                        if (IDLE_TIMEOUT == 0) begin
                            timer_d = '0;
                        end else if (timer_q == TMR_W'(TMR_LAST)) begin
                            idle_to_err = 1'b1;
                            timer_d     = '0;
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_HUNT;
                    ones_d  = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Collect new errors; a due expectation fails when its strobe is missing
    always_comb begin
        err_new    = '0;
        err_new[0] = En && flag_pipe_q[FLAG_LAT-1]   && !Rx_FlagDetect;
        err_new[1] = En && abort_pipe_q[ABORT_LAT-1] && !Rx_AbortSignal;
        err_new[2] = idle_data_err;
        err_new[3] = idle_to_err;
    end

    // Clear first, then merge new errors so a same-cycle error survives the clear
    always_comb begin
        base_flag  = ClrErr ? '0 : err_flag_q;
        base_cnt   = ClrErr ? '0 : err_cnt_q;
        base_valid = ClrErr ? 1'b0 : first_valid_q;
        base_code  = ClrErr ? 2'd0 : first_code_q;

        err_pop = {2'b00, err_new[0]} + {2'b00, err_new[1]}
                + {2'b00, err_new[2]} + {2'b00, err_new[3]};
        cnt_sum = {3'b000, base_cnt} + SUM_W'(err_pop);

        if (err_new[0]) begin
            err_low = 2'd0;
        end else if (err_new[1]) begin
            err_low = 2'd1;
        end else if (err_new[2]) begin
            err_low = 2'd2;
        end else begin
            err_low = 2'd3;
        end

        err_flag_d = base_flag | err_new;
        err_cnt_d  = (cnt_sum[SUM_W-1:CNT_W] != '0) ? '1 : cnt_sum[CNT_W-1:0];

        first_valid_d = base_valid;
        first_code_d  = base_code;
        if (!base_valid && (err_new != '0)) begin
            first_valid_d = 1'b1;
            first_code_d  = err_low;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sreg_q        <= '0;
            flag_pipe_q   <= '0;
            abort_pipe_q  <= '0;
            state_q       <= S_HUNT;
            ones_q        <= '0;
            timer_q       <= '0;
            cap_q         <= '0;
            err_flag_q    <= '0;
            err_cnt_q     <= '0;
            first_code_q  <= '0;
            first_valid_q <= 1'b0;
        end else begin
            sreg_q        <= sreg_d;
            flag_pipe_q   <= flag_pipe_d;
            abort_pipe_q  <= abort_pipe_d;
            state_q       <= state_d;
            ones_q        <= ones_d;
            timer_q       <= timer_d;
            cap_q         <= cap_d;
            err_flag_q    <= err_flag_d;
            err_cnt_q     <= err_cnt_d;
            first_code_q  <= first_code_d;
            first_valid_q <= first_valid_d;
        end
    end

    assign ErrFlag       = err_flag_q;
    assign ErrCnt        = err_cnt_q;
    assign FirstErrCode  = first_code_q;
    assign FirstErrValid = first_valid_q;
    assign Idle          = (state_q == S_IDLE);

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Scoreboard bench for hdlc_rx_monitor: a run-length / due-list reference model predicts
// every cycle's outputs; a negedge monitor pops and compares. Second instance uses CNT_W=2.
module tb_hdlc_rx_monitor;

    localparam int unsigned FLAG_LAT     = 2;
    localparam int unsigned ABORT_LAT    = 1;
    localparam int unsigned IDLE_LEN     = 8;
    localparam int unsigned IDLE_TIMEOUT = 100;
    localparam int          CNT_MAX_A    = 65535;
    localparam int          CNT_MAX_B    = 3;

    logic        Clk;
    logic        Rst;
    logic        En;
    logic        Rx;
    logic        Rx_FlagDetect;
    logic        Rx_ValidFrame;
    logic        Rx_AbortDetect;
    logic        Rx_AbortSignal;
    logic [31:0] DataOut;
    logic        ClrErr;

    logic [3:0]  ErrFlag_a,  ErrFlag_b;
    logic [15:0] ErrCnt_a;
    logic [1:0]  ErrCnt_b;
    logic [1:0]  FirstErrCode_a, FirstErrCode_b;
    logic        FirstErrValid_a, FirstErrValid_b;
    logic        Idle_a, Idle_b;

    hdlc_rx_monitor #(
        .FLAG_LAT(FLAG_LAT), .ABORT_LAT(ABORT_LAT), .IDLE_LEN(IDLE_LEN),
        .IDLE_TIMEOUT(IDLE_TIMEOUT), .CNT_W(16)
    ) u_dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Rx(Rx), .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_ValidFrame(Rx_ValidFrame), .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_AbortSignal(Rx_AbortSignal), .DataOut(DataOut), .ClrErr(ClrErr),
        .ErrFlag(ErrFlag_a), .ErrCnt(ErrCnt_a), .FirstErrCode(FirstErrCode_a),
        .FirstErrValid(FirstErrValid_a), .Idle(Idle_a)
    );

    hdlc_rx_monitor #(
        .FLAG_LAT(FLAG_LAT), .ABORT_LAT(ABORT_LAT), .IDLE_LEN(IDLE_LEN),
        .IDLE_TIMEOUT(IDLE_TIMEOUT), .CNT_W(2)
    ) u_dut_sat (
        .Clk(Clk), .Rst(Rst), .En(En), .Rx(Rx), .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_ValidFrame(Rx_ValidFrame), .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_AbortSignal(Rx_AbortSignal), .DataOut(DataOut), .ClrErr(ClrErr),
        .ErrFlag(ErrFlag_b), .ErrCnt(ErrCnt_b), .FirstErrCode(FirstErrCode_b),
        .FirstErrValid(FirstErrValid_b), .Idle(Idle_b)
    );

    typedef struct {
        logic [3:0] flag;
        int         total;
        logic [1:0] code;
        logic       valid;
        logic       idle;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_x;
    int          checks;
    int          failures;

    // Reference model state
    int          cyc;
    logic [7:0]  hist;
    int          flag_due[$];
    int          abort_due[$];
    int          run_len;
    logic [31:0] cap;
    logic [3:0]  m_flag;
    int          m_total;
    logic [1:0]  m_code;
    logic        m_valid;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, need end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h need=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock edge: the model consumes the inputs the DUT just sampled
    task automatic model_edge();
        logic [3:0] e;
        exp_t       x;
        e = '0;
        if (!Rst) begin
            hist = '0;
            flag_due.delete();
            abort_due.delete();
            run_len = 0;
            cap     = '0;
            m_flag  = '0;
            m_total = 0;
            m_code  = '0;
            m_valid = 1'b0;
        end else begin
            if (!En) begin
                hist = '0;
                flag_due.delete();
                abort_due.delete();
                run_len = 0;
            end else begin
                hist = {hist[6:0], Rx};
                if (flag_due.size() > 0 && flag_due[0] == cyc) begin
                    void'(flag_due.pop_front());
                    if (!Rx_FlagDetect) e[0] = 1'b1;
                end
                if (hist == 8'h7E) flag_due.push_back(cyc + int'(FLAG_LAT));
                if (abort_due.size() > 0 && abort_due[0] == cyc) begin
                    void'(abort_due.pop_front());
                    if (!Rx_AbortSignal) e[1] = 1'b1;
                end
                if (Rx_AbortDetect && Rx_ValidFrame) abort_due.push_back(cyc + int'(ABORT_LAT));
                if (Rx) begin
                    run_len++;
                    if (run_len == int'(IDLE_LEN)) begin
                        cap = DataOut;
                    end else if (run_len > int'(IDLE_LEN)) begin
                        if (DataOut != cap) begin
                            e[2] = 1'b1;
                            cap  = DataOut;
                        end
                        if (IDLE_TIMEOUT != 0 &&
                            ((run_len - int'(IDLE_LEN)) % int'(IDLE_TIMEOUT)) == 0)
                            e[3] = 1'b1;
                    end
                end else begin
                    run_len = 0;
                end
            end
            if (ClrErr) begin
                m_flag  = '0;
                m_total = 0;
                m_code  = '0;
                m_valid = 1'b0;
            end
            m_flag  = m_flag | e;
            m_total = m_total + $countones(e);
            if (!m_valid && e != '0) begin
                m_valid = 1'b1;
                m_code  = e[0] ? 2'd0 : e[1] ? 2'd1 : e[2] ? 2'd2 : 2'd3;
            end
        end
        x.flag  = m_flag;
        x.total = m_total;
        x.code  = m_code;
        x.valid = m_valid;
        x.idle  = (run_len >= int'(IDLE_LEN));
        exp_q.push_back(x);
        cyc++;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        model_edge();
    endtask

    task automatic send_flag();
        Rx = 1'b0;
        tick();
        repeat (6) begin
            Rx = 1'b1;
            tick();
        end
        Rx = 1'b0;
        tick();
    endtask

    task automatic clear_errs();
        ClrErr = 1'b1;
        tick();
        ClrErr = 1'b0;
    endtask

    // Monitor: compare every presented output cycle against the queued prediction
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            chk("sb_errflag",   32'(ErrFlag_a),       32'(mon_x.flag));
            chk("sb_errcnt",    32'(ErrCnt_a),        32'(sat(mon_x.total, CNT_MAX_A)));
            chk("sb_firstcode", 32'(FirstErrCode_a),  32'(mon_x.code));
            chk("sb_firstval",  32'(FirstErrValid_a), 32'(mon_x.valid));
            chk("sb_idle",      32'(Idle_a),          32'(mon_x.idle));
            chk("sb_errflag_b", 32'(ErrFlag_b),       32'(mon_x.flag));
            chk("sb_errcnt_b",  32'(ErrCnt_b),        32'(sat(mon_x.total, CNT_MAX_B)));
        end
    end

    initial begin
        logic [7:0] tx;
        int         bits_left;
        checks = 0; failures = 0; cyc = 0;
        hist = '0; run_len = 0; cap = '0;
        m_flag = '0; m_total = 0; m_code = '0; m_valid = 1'b0;
        Rst = 1'b0; En = 1'b1; Rx = 1'b0; Rx_FlagDetect = 1'b0; Rx_ValidFrame = 1'b0;
        Rx_AbortDetect = 1'b0; Rx_AbortSignal = 1'b0; DataOut = '0; ClrErr = 1'b0;

        repeat (3) tick();
        chk("reset_errflag", 32'(ErrFlag_a), 32'h0);
        chk("reset_errcnt",  32'(ErrCnt_a),  32'h0);
        chk("reset_idle",    32'(Idle_a),    32'h0);
        Rst = 1'b1;

        // Flag answered exactly FLAG_LAT cycles after the closing 0
        send_flag();
        tick();
        Rx_FlagDetect = 1'b1;
        tick();
        Rx_FlagDetect = 1'b0;
        tick();
        chk("flag_ok_errflag", 32'(ErrFlag_a), 32'h0);
        chk("flag_ok_errcnt",  32'(ErrCnt_a),  32'h0);

        // Flag never answered
        send_flag();
        repeat (3) tick();
        chk("flag_miss_errflag", 32'(ErrFlag_a),       32'h1);
        chk("flag_miss_errcnt",  32'(ErrCnt_a),        32'h1);
        chk("flag_miss_code",    32'(FirstErrCode_a),  32'h0);
        chk("flag_miss_valid",   32'(FirstErrValid_a), 32'h1);
        clear_errs();

        // Abort with missing, then present, Rx_AbortSignal
        for (int pass = 0; pass < 2; pass++) begin
            Rx_AbortDetect = 1'b1; Rx_ValidFrame = 1'b1;
            tick();
            Rx_AbortDetect = 1'b0; Rx_ValidFrame = 1'b0;
            Rx_AbortSignal = (pass == 1);
            tick();
            Rx_AbortSignal = 1'b0;
            tick();
            chk("abort_errflag", 32'(ErrFlag_a), (pass == 0) ? 32'h2 : 32'h0);
            clear_errs();
        end

        // Idle entry, DataOut change while idle, exit on a 0
        DataOut = 32'h0;
        repeat (8) begin
            Rx = 1'b1;
            tick();
        end
        chk("idle_enter", 32'(Idle_a), 32'h1);
        repeat (3) tick();
        DataOut = 32'h5;
        tick();
        tick();
        chk("idle_data_errflag", 32'(ErrFlag_a), 32'h4);
        chk("idle_data_errcnt",  32'(ErrCnt_a),  32'h1);
        Rx = 1'b0;
        tick();
        chk("idle_exit", 32'(Idle_a), 32'h0);
        clear_errs();

        // Idle timeout repeating every IDLE_TIMEOUT cycles
        repeat (8 + 250) begin
            Rx = 1'b1;
            tick();
        end
        chk("timeout_errflag", 32'(ErrFlag_a), 32'h8);
        chk("timeout_errcnt",  32'(ErrCnt_a),  32'h2);

        // Clear colliding with a fresh flag error: the new error survives
        send_flag();
        tick();
        ClrErr = 1'b1;
        tick();
        ClrErr = 1'b0;
        tick();
        chk("clr_collide_errcnt", 32'(ErrCnt_a),       32'h1);
        chk("clr_collide_code",   32'(FirstErrCode_a), 32'h0);
        chk("clr_collide_flag",   32'(ErrFlag_a),      32'h1);
        clear_errs();

        // Five errors saturate the 2-bit counter
        repeat (5) begin
            send_flag();
            repeat (2) tick();
        end
        tick();
        chk("sat_errcnt_b", 32'(ErrCnt_b), 32'h3);
        chk("sat_errcnt_a", 32'(ErrCnt_a), 32'h5);

        // Reset while a flag expectation is pending
        send_flag();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        repeat (3) tick();
        chk("midrst_errflag", 32'(ErrFlag_a),       32'h0);
        chk("midrst_errcnt",  32'(ErrCnt_a),        32'h0);
        chk("midrst_valid",   32'(FirstErrValid_a), 32'h0);

        // Disable while a flag expectation is pending
        send_flag();
        En = 1'b0;
        tick();
        En = 1'b1;
        repeat (3) tick();
        chk("en_flush_errflag", 32'(ErrFlag_a), 32'h0);

        // Randomised traffic: byte stream rich in flags and idle fill
        bits_left = 0;
        tx = '0;
        for (int i = 0; i < 3000; i++) begin
            if (bits_left == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: tx = 8'h7E;
                    2:    tx = 8'hFF;
                    default: tx = 8'($urandom);
                endcase
                bits_left = 8;
            end
            Rx = tx[7];
            tx = {tx[6:0], 1'b0};
            bits_left--;
            Rst    = ($urandom_range(0, 499) != 0);
            En     = ($urandom_range(0, 199) != 0);
            ClrErr = ($urandom_range(0, 99) == 0);
            if (flag_due.size() > 0 && flag_due[0] == cyc)
                Rx_FlagDetect = ($urandom_range(0, 5) != 0);
            else
                Rx_FlagDetect = ($urandom_range(0, 15) == 0);
            if (abort_due.size() > 0 && abort_due[0] == cyc)
                Rx_AbortSignal = ($urandom_range(0, 5) != 0);
            else
                Rx_AbortSignal = ($urandom_range(0, 15) == 0);
            Rx_AbortDetect = ($urandom_range(0, 7) == 0);
            Rx_ValidFrame  = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 31) == 0) DataOut = $urandom;
            tick();
        end

        Rst = 1'b1; En = 1'b1; ClrErr = 1'b0;
        repeat (2) tick();
        @(negedge Clk);
        @(negedge Clk);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
